// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, addresses the combinational
// instruction ROM and hands registered instruction words to decode.
module instr_fetch_unit #(
    parameter int                     PC_WIDTH    = 9,
    parameter int                     INSTR_WIDTH = 9,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = 9'h1FF,
    parameter int                     CNT_WIDTH   = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start_i,
    input  logic                   stall_i,
    input  logic                   branch_i,
    input  logic [PC_WIDTH-1:0]    branch_target_i,
    output logic [PC_WIDTH-1:0]    rom_addr_o,
    input  logic [INSTR_WIDTH-1:0] rom_data_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic                   instr_valid_o,
    output logic [PC_WIDTH-1:0]    instr_pc_o,
    output logic                   halt_o,
    output logic [CNT_WIDTH-1:0]   fetch_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0]  PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                   state_r, state_nxt_s;
    logic [PC_WIDTH-1:0]      pc_r, pc_nxt_s;
    logic [INSTR_WIDTH-1:0]   instr_r, instr_nxt_s;
    logic [PC_WIDTH-1:0]      instr_pc_r, instr_pc_nxt_s;
    logic                     valid_r, valid_nxt_s;
    logic                     halt_r, halt_nxt_s;
    logic [CNT_WIDTH-1:0]     cnt_r, cnt_nxt_s;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            instr_r    <= '0;
            instr_pc_r <= '0;
            valid_r    <= 1'b0;
            halt_r     <= 1'b0;
            cnt_r      <= '0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            instr_r    <= instr_nxt_s;
            instr_pc_r <= instr_pc_nxt_s;
            valid_r    <= valid_nxt_s;
            halt_r     <= halt_nxt_s;
            cnt_r      <= cnt_nxt_s;
        end
    end

    // Next-state and datapath update; everything holds unless a branch below says otherwise
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        instr_nxt_s    = instr_r;
        instr_pc_nxt_s = instr_pc_r;
        valid_nxt_s    = valid_r;
        halt_nxt_s     = halt_r;
        cnt_nxt_s      = cnt_r;

        case (state_r)
            ST_IDLE: begin
                valid_nxt_s = 1'b0;
                if (start_i) begin
                    state_nxt_s = ST_FETCH;
                    pc_nxt_s    = RESET_PC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_FETCH: begin
                if (start_i) begin
                    pc_nxt_s    = RESET_PC;
                    valid_nxt_s = 1'b0;
                end else if (branch_i && valid_r) begin
                    // Word on the ROM bus this cycle is wrong-path: drop it, no halt check
                    pc_nxt_s    = branch_target_i;
                    valid_nxt_s = 1'b0;
                end else if (stall_i) begin
                    valid_nxt_s = valid_r;
                end else begin
                    instr_nxt_s    = rom_data_i;
                    instr_pc_nxt_s = pc_r;
                    valid_nxt_s    = 1'b1;
                    cnt_nxt_s      = cnt_r + CNT_ONE;
                    if (rom_data_i == HALT_INSTR) begin
                        state_nxt_s = ST_HALTED;
                        halt_nxt_s  = 1'b1;
                    end else begin
                        pc_nxt_s = pc_r + PC_ONE;
                    end
                end
            end

            ST_HALTED: begin
                if (start_i) begin
                    state_nxt_s = ST_FETCH;
                    pc_nxt_s    = RESET_PC;
                    halt_nxt_s  = 1'b0;
                    valid_nxt_s = 1'b0;
                end else if (!stall_i) begin
                    valid_nxt_s = 1'b0;
                end else begin
                    valid_nxt_s = valid_r;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    assign rom_addr_o    = pc_r;
    assign instr_o       = instr_r;
    assign instr_valid_o = valid_r;
    assign instr_pc_o    = instr_pc_r;
    assign halt_o        = halt_r;
    assign fetch_count_o = cnt_r;

endmodule
